// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions: opcode encodings, the opcode driven
//               onto the ALU when nobody holds a grant, and datapath widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  localparam logic [2:0] ADD16 = 3'b000;
  localparam logic [2:0] SUB16 = 3'b001;
  localparam logic [2:0] AND16 = 3'b010;
  localparam logic [2:0] NOR16 = 3'b011;
  localparam logic [2:0] SLL16 = 3'b100;
  localparam logic [2:0] SRL16 = 3'b101;
  localparam logic [2:0] LHB16 = 3'b110;
  localparam logic [2:0] SRA16 = 3'b111;

  localparam logic [2:0] IDLE_OP = ADD16;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Bundle of the two requester channels and the shared-ALU
//               channel seen by alu_share_arbiter.
// Ports       : r0_* / r1_*  request, lock, operands, flag_wr, gnt, rsp
//               alu_*        operands out to the ALU, alu_dst result back
//               modport slave  : arbiter view
//               modport master : requester / ALU view
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHW   = SHAMT_W
);

  logic             r0_req,  r1_req;
  logic             r0_lock, r1_lock;
  logic [2:0]       r0_ops,  r1_ops;
  logic [WIDTH-1:0] r0_src1, r1_src1;
  logic [WIDTH-1:0] r0_src0, r1_src0;
  logic [SHW-1:0]   r0_shamt, r1_shamt;
  logic             r0_flag_wr, r1_flag_wr;
  logic             r0_gnt,  r1_gnt;
  logic             r0_rsp_valid, r1_rsp_valid;
  logic [WIDTH-1:0] r0_rsp_data,  r1_rsp_data;

  logic [2:0]       alu_ops;
  logic [WIDTH-1:0] alu_src1, alu_src0;
  logic [SHW-1:0]   alu_shamt;
  logic             alu_hold_flags;
  logic [WIDTH-1:0] alu_dst;

  modport slave (
    input  r0_req, r0_lock, r0_ops, r0_src1, r0_src0, r0_shamt, r0_flag_wr,
    input  r1_req, r1_lock, r1_ops, r1_src1, r1_src0, r1_shamt, r1_flag_wr,
    input  alu_dst,
    output r0_gnt, r0_rsp_valid, r0_rsp_data,
    output r1_gnt, r1_rsp_valid, r1_rsp_data,
    output alu_ops, alu_src1, alu_src0, alu_shamt, alu_hold_flags
  );

  modport master (
    output r0_req, r0_lock, r0_ops, r0_src1, r0_src0, r0_shamt, r0_flag_wr,
    output r1_req, r1_lock, r1_ops, r1_src1, r1_src0, r1_shamt, r1_flag_wr,
    output alu_dst,
    input  r0_gnt, r0_rsp_valid, r0_rsp_data,
    input  r1_gnt, r1_rsp_valid, r1_rsp_data,
    input  alu_ops, alu_src1, alu_src0, alu_shamt, alu_hold_flags
  );

endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_lock_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arb2
// Description : Two-way round-robin picker with grant lock and a starvation
//               counter that overrides a lock held too long.
// Ports       : clk, rst_n      clock, async active-low reset
//               i_req[1:0]      request per requester
//               i_lock[1:0]     lock request per requester (for next cycle)
//               o_gnt[1:0]      one-hot (or zero) combinational grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lock_arb2 #(
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] i_req,
  input  wire logic [1:0] i_lock,
  output logic      [1:0] o_gnt
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic       r_last_winner;
  logic       r_locked;
  logic [3:0] r_wait_cnt;

  logic       w_any;
  logic       w_winner;
  logic [3:0] w_wait_nxt;

  always_comb begin
    w_any    = 1'b0;
    w_winner = 1'b0;
    case (i_req)
      2'b01: begin
        w_any    = 1'b1;
        w_winner = 1'b0;
      end
      2'b10: begin
        w_any    = 1'b1;
        w_winner = 1'b1;
      end
      2'b11: begin
        w_any    = 1'b1;
        // A held lock keeps the previous winner until the loser has been
        // denied STARVE_LIMIT consecutive locked cycles.
        if (r_locked && (r_wait_cnt < c_starve_limit)) begin
          w_winner = r_last_winner;
        end else begin
          w_winner = ~r_last_winner;
        end
      end
      default: ;
    endcase
  end

  assign o_gnt = w_any ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

  // The same side keeps losing only while the winner repeats under
  // contention; any alternation, single request or idle cycle restarts it.
  always_comb begin
    w_wait_nxt = 4'd0;
    if ((i_req == 2'b11) && (w_winner == r_last_winner)) begin
      w_wait_nxt = (r_wait_cnt >= c_starve_limit) ? c_starve_limit
                                                  : r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_winner <= 1'b1;
      r_locked      <= 1'b0;
      r_wait_cnt    <= 4'd0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      if (w_any) begin
        r_last_winner <= w_winner;
        r_locked      <= i_lock[w_winner];
      end else begin
        r_locked      <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one 16-bit ALU between the execute stage (r0) and the
//               auxiliary unit (r1). Muxes the winner's operands onto the
//               ALU, drives the ALU flag-hold, and returns the result to the
//               winner one cycle later.
// Ports       : clk, rst_n  clock, async active-low reset
//               bus         alu_share_arbiter_if.slave (requesters + ALU)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH        = DATA_W,
  parameter int SHW          = SHAMT_W,
  parameter int STARVE_LIMIT = 4
) (
  input wire logic            clk,
  input wire logic            rst_n,
  alu_share_arbiter_if.slave  bus
);

  logic [1:0]       w_gnt;
  logic [2:0]       w_ops;
  logic [WIDTH-1:0] w_src1;
  logic [WIDTH-1:0] w_src0;
  logic [SHW-1:0]   w_shamt;
  logic             w_hold;

  logic             r_rsp_valid0, r_rsp_valid1;
  logic [WIDTH-1:0] r_rsp_data0,  r_rsp_data1;

  rr_lock_arb2 #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  ({bus.r1_req,  bus.r0_req}),
    .i_lock ({bus.r1_lock, bus.r0_lock}),
    .o_gnt  (w_gnt)
  );

  // With no grant the ALU sees a benign zero op and flags are frozen.
  always_comb begin
    w_ops   = IDLE_OP;
    w_src1  = '0;
    w_src0  = '0;
    w_shamt = '0;
    w_hold  = 1'b1;
    if (w_gnt[0]) begin
      w_ops   = bus.r0_ops;
      w_src1  = bus.r0_src1;
      w_src0  = bus.r0_src0;
      w_shamt = bus.r0_shamt;
      w_hold  = ~bus.r0_flag_wr;
    end else if (w_gnt[1]) begin
      w_ops   = bus.r1_ops;
      w_src1  = bus.r1_src1;
      w_src0  = bus.r1_src0;
      w_shamt = bus.r1_shamt;
      w_hold  = ~bus.r1_flag_wr;
    end
  end

  assign bus.alu_ops        = w_ops;
  assign bus.alu_src1       = w_src1;
  assign bus.alu_src0       = w_src0;
  assign bus.alu_shamt      = w_shamt;
  assign bus.alu_hold_flags = w_hold;
  assign bus.r0_gnt         = w_gnt[0];
  assign bus.r1_gnt         = w_gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_rsp_data0  <= '0;
      r_rsp_data1  <= '0;
    end else begin
      r_rsp_valid0 <= w_gnt[0];
      r_rsp_valid1 <= w_gnt[1];
      if (w_gnt[0]) r_rsp_data0 <= bus.alu_dst;
      if (w_gnt[1]) r_rsp_data1 <= bus.alu_dst;
    end
  end

  assign bus.r0_rsp_valid = r_rsp_valid0;
  assign bus.r1_rsp_valid = r_rsp_valid1;
  assign bus.r0_rsp_data  = r_rsp_data0;
  assign bus.r1_rsp_data  = r_rsp_data1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed self-checking bench for alu_share_arbiter with a
//               small behavioural ALU (result + N/Z flags honouring hold).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic flag_n, flag_z;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(16), .SHW(4)) bus ();

  alu_share_arbiter #(
    .WIDTH        (16),
    .SHW          (4),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU.
  always_comb begin
    case (bus.alu_ops)
      ADD16:   bus.alu_dst = bus.alu_src1 + bus.alu_src0;
      SUB16:   bus.alu_dst = bus.alu_src1 - bus.alu_src0;
      AND16:   bus.alu_dst = bus.alu_src1 & bus.alu_src0;
      NOR16:   bus.alu_dst = ~(bus.alu_src1 | bus.alu_src0);
      SLL16:   bus.alu_dst = bus.alu_src1 << bus.alu_shamt;
      SRL16:   bus.alu_dst = bus.alu_src1 >> bus.alu_shamt;
      LHB16:   bus.alu_dst = {bus.alu_src0[7:0], bus.alu_src1[7:0]};
      default: bus.alu_dst = 16'($signed(bus.alu_src1) >>> bus.alu_shamt);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!bus.alu_hold_flags) begin
      flag_n <= bus.alu_dst[15];
      flag_z <= (bus.alu_dst == 16'h0000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.r0_req = 0; bus.r0_lock = 0; bus.r0_ops = ADD16; bus.r0_src1 = 0;
    bus.r0_src0 = 0; bus.r0_shamt = 0; bus.r0_flag_wr = 0;
    bus.r1_req = 0; bus.r1_lock = 0; bus.r1_ops = ADD16; bus.r1_src1 = 0;
    bus.r1_src0 = 0; bus.r1_shamt = 0; bus.r1_flag_wr = 0;
  endtask

  task automatic set_r0(input logic req, input logic lock, input logic [2:0] ops,
                        input logic [15:0] s1, input logic [15:0] s0,
                        input logic [3:0] sh, input logic fw);
    bus.r0_req = req; bus.r0_lock = lock; bus.r0_ops = ops; bus.r0_src1 = s1;
    bus.r0_src0 = s0; bus.r0_shamt = sh; bus.r0_flag_wr = fw;
  endtask

  task automatic set_r1(input logic req, input logic lock, input logic [2:0] ops,
                        input logic [15:0] s1, input logic [15:0] s0,
                        input logic [3:0] sh, input logic fw);
    bus.r1_req = req; bus.r1_lock = lock; bus.r1_ops = ops; bus.r1_src1 = s1;
    bus.r1_src0 = s0; bus.r1_shamt = sh; bus.r1_flag_wr = fw;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.r1_rsp_valid, bus.r0_rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid: got %b required 00", {bus.r1_rsp_valid, bus.r0_rsp_valid});
    end
    checks++;
    if (bus.r0_rsp_data !== 16'h0 || bus.r1_rsp_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h required 0000/0000", bus.r0_rsp_data, bus.r1_rsp_data);
    end
    checks++;
    if ({bus.r1_gnt, bus.r0_gnt} !== 2'b00 || bus.alu_hold_flags !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: gnt %b hold %b required 00 1",
               {bus.r1_gnt, bus.r0_gnt}, bus.alu_hold_flags);
    end
  endtask

  task automatic test_first_grant();
    rst_n = 1;
    set_r0(1, 0, ADD16, 16'h0003, 16'h0004, 4'd0, 1);
    #1;
    checks++;
    if ({bus.r1_gnt, bus.r0_gnt} !== 2'b01 || bus.alu_hold_flags !== 1'b0) begin
      errors++;
      $display("FAIL first_gnt: gnt %b hold %b required 01 0",
               {bus.r1_gnt, bus.r0_gnt}, bus.alu_hold_flags);
    end
    checks++;
    if (bus.alu_ops !== ADD16 || bus.alu_src1 !== 16'h0003 || bus.alu_src0 !== 16'h0004) begin
      errors++;
      $display("FAIL first_mux: ops %b src1 %h src0 %h required 000 0003 0004",
               bus.alu_ops, bus.alu_src1, bus.alu_src0);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.r0_rsp_valid !== 1'b1 || bus.r0_rsp_data !== 16'h0007 || bus.r1_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_rsp: v0 %b d0 %h v1 %b required 1 0007 0",
               bus.r0_rsp_valid, bus.r0_rsp_data, bus.r1_rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.r0_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_pulse: v0 %b required 0", bus.r0_rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_r0(1, 0, ADD16, 16'h0001, 16'h0001, 4'd0, 1);
    set_r1(1, 0, SLL16, 16'h0001, 16'h0000, 4'd4, 0);
    for (int i = 0; i < 4; i++) begin
      logic exp1;
      exp1 = (i % 2) == 1;
      #1;
      checks++;
      if ({bus.r1_gnt, bus.r0_gnt} !== (exp1 ? 2'b10 : 2'b01) || bus.alu_hold_flags !== exp1) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: gnt %b hold %b required %b %b", i,
                 {bus.r1_gnt, bus.r0_gnt}, bus.alu_hold_flags, exp1 ? 2'b10 : 2'b01, exp1);
      end
      @(negedge clk);
      checks++;
      if (exp1 ? (bus.r1_rsp_valid !== 1'b1 || bus.r1_rsp_data !== 16'h0010 || bus.r0_rsp_valid !== 1'b0)
               : (bus.r0_rsp_valid !== 1'b1 || bus.r0_rsp_data !== 16'h0002 || bus.r1_rsp_valid !== 1'b0)) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: v0 %b d0 %h v1 %b d1 %h required winner r%0d data %h", i,
                 bus.r0_rsp_valid, bus.r0_rsp_data, bus.r1_rsp_valid, bus.r1_rsp_data,
                 exp1, exp1 ? 16'h0010 : 16'h0002);
      end
    end
  endtask

  // Runs straight after test_round_robin: last flag writer was r0 (0x0002).
  task automatic test_flag_hold();
    set_r0(0, 0, ADD16, 16'h0000, 16'h0000, 4'd0, 0);
    set_r1(1, 0, SUB16, 16'h0005, 16'h0005, 4'd0, 0);
    #1;
    checks++;
    if (bus.r1_gnt !== 1'b1 || bus.alu_hold_flags !== 1'b1) begin
      errors++;
      $display("FAIL hold_drive: gnt1 %b hold %b required 1 1", bus.r1_gnt, bus.alu_hold_flags);
    end
    @(negedge clk);
    checks++;
    if (flag_z !== 1'b0 || bus.r1_rsp_valid !== 1'b1 || bus.r1_rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL hold_z: Z %b v1 %b d1 %h required 0 1 0000",
               flag_z, bus.r1_rsp_valid, bus.r1_rsp_data);
    end
    set_r1(0, 0, ADD16, 16'h0000, 16'h0000, 4'd0, 0);
    set_r0(1, 0, SUB16, 16'h0005, 16'h0005, 4'd0, 1);
    #1;
    checks++;
    if (bus.alu_hold_flags !== 1'b0) begin
      errors++;
      $display("FAIL write_drive: hold %b required 0", bus.alu_hold_flags);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
      errors++;
      $display("FAIL write_flags: Z %b N %b required 1 0", flag_z, flag_n);
    end
  endtask

  task automatic test_lock_starve();
    logic [6:0] exp_seq;
    exp_seq = 7'b0100000; // bit i = 1 means r1 wins cycle i
    do_reset();
    set_r0(1, 1, ADD16, 16'h0001, 16'h0001, 4'd0, 0);
    set_r1(1, 0, ADD16, 16'h0002, 16'h0002, 4'd0, 0);
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if ({bus.r1_gnt, bus.r0_gnt} !== (exp_seq[i] ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL starve_gnt[%0d]: gnt %b required %b", i,
                 {bus.r1_gnt, bus.r0_gnt}, exp_seq[i] ? 2'b10 : 2'b01);
      end
      @(negedge clk);
      if (exp_seq[i]) begin
        checks++;
        if (bus.r1_rsp_valid !== 1'b1 || bus.r1_rsp_data !== 16'h0004 || bus.r0_rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL starve_rsp: v1 %b d1 %h v0 %b required 1 0004 0",
                   bus.r1_rsp_valid, bus.r1_rsp_data, bus.r0_rsp_valid);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_r0(1, 1, ADD16, 16'h0001, 16'h0001, 4'd0, 0);
    @(negedge clk);
    checks++;
    if (bus.r0_rsp_valid !== 1'b1 || bus.r0_rsp_data !== 16'h0002) begin
      errors++;
      $display("FAIL midrst_pre: v0 %b d0 %h required 1 0002", bus.r0_rsp_valid, bus.r0_rsp_data);
    end
    rst_n = 0;
    #1;
    checks++;
    if (bus.r0_rsp_valid !== 1'b0 || bus.r0_rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_async: v0 %b d0 %h required 0 0000", bus.r0_rsp_valid, bus.r0_rsp_data);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({bus.r1_rsp_valid, bus.r0_rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_nopulse: valid %b required 00", {bus.r1_rsp_valid, bus.r0_rsp_valid});
    end
    set_r0(1, 0, ADD16, 16'h0001, 16'h0001, 4'd0, 0);
    set_r1(1, 0, ADD16, 16'h0002, 16'h0002, 4'd0, 0);
    #1;
    checks++;
    if ({bus.r1_gnt, bus.r0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_first: gnt %b required 01", {bus.r1_gnt, bus.r0_gnt});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_idle_lock();
    do_reset();
    set_r0(1, 1, NOR16, 16'h1234, 16'h00FF, 4'd3, 1);
    set_r1(1, 0, SRA16, 16'h8000, 16'h0F0F, 4'd5, 1);
    #1;
    checks++;
    if ({bus.r1_gnt, bus.r0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL idle_pre: gnt %b required 01", {bus.r1_gnt, bus.r0_gnt});
    end
    @(negedge clk);
    bus.r0_req = 0;
    bus.r1_req = 0;
    #1;
    checks++;
    if (bus.alu_ops !== 3'b000 || bus.alu_src1 !== 16'h0 || bus.alu_src0 !== 16'h0 ||
        bus.alu_shamt !== 4'h0 || bus.alu_hold_flags !== 1'b1 || {bus.r1_gnt, bus.r0_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL idle_drive: ops %b src1 %h src0 %h sh %h hold %b gnt %b required 000 0000 0000 0 1 00",
               bus.alu_ops, bus.alu_src1, bus.alu_src0, bus.alu_shamt,
               bus.alu_hold_flags, {bus.r1_gnt, bus.r0_gnt});
    end
    @(negedge clk);
    bus.r0_req = 1;
    bus.r1_req = 1;
    #1;
    checks++;
    if ({bus.r1_gnt, bus.r0_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL idle_unlock: gnt %b required 10", {bus.r1_gnt, bus.r0_gnt});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_flag_hold();
    test_lock_starve();
    test_mid_reset();
    test_idle_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
